// File: rtl/bicubic_line_wr_ctrl_pkg.sv
// Shared constants and write-FSM encoding for the bicubic line-buffer bank.
package bicubic_pkg;
    localparam int DEF_IMG_W = 960;
    localparam int DEF_IMG_H = 540;
    localparam int DEF_AW    = 11;
    localparam int PIX_W     = 8;
    localparam int NUM_LINES = 4;
    localparam int PTR_W     = $clog2(NUM_LINES);
    localparam int LIDX_W    = 11;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } wr_state_e;
endpackage

// File: rtl/bicubic_line_wr_ctrl_sync.sv
// Toggle-to-pulse crossing: 2-flop synchroniser plus edge-detect flop.
// Pulse appears 2-3 write clocks after the toggle edge; no backpressure.
module toggle_sync_pulse (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tgl_i,
    output logic pulse_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], tgl_i};
        end
    end

    assign pulse_o = sync_q[1] ^ sync_q[2];
endmodule

// File: rtl/bicubic_line_wr_ctrl.sv
// Round-robin writer of pixel rows into 4 line buffers; write path 1 cycle after transfer.
// Backpressure: pix_ready drops while all 4 buffered lines are unconsumed.
module bicubic_line_wr_ctrl
    import bicubic_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = DEF_AW
) (
    input  logic              clk_in1,
    input  logic              rst_n,
    input  logic              pix_sof,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    input  logic              rd_rel_tgl,
    output logic              bram0_wenb,
    output logic              bram1_wenb,
    output logic              bram2_wenb,
    output logic              bram3_wenb,
    output logic [AW-1:0]     bram_waddr,
    output logic [PIX_W-1:0]  bram_wdata,
    output logic              line_done,
    output logic              frame_done,
    output logic [LIDX_W-1:0] wr_line_idx,
    output logic [CNT_W-1:0]  buf_cnt,
    output logic              rel_err
);
    localparam logic [AW-1:0]     COL_LAST  = AW'(IMG_W - 1);
    localparam logic [LIDX_W-1:0] LINE_LAST = LIDX_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_LINES);

    wr_state_e            state_q, state_d;
    logic                 run_q;
    logic [AW-1:0]        col_q, col_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LIDX_W-1:0]    lidx_q, lidx_d;
    logic                 rel_err_q, rel_err_d;
    logic [NUM_LINES-1:0] wen_q, wen_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [PIX_W-1:0]     wdata_q, wdata_d;
    logic                 line_done_q, line_done_d;
    logic                 frame_done_q, frame_done_d;
    logic                 rel_pulse, xfer, abort, line_end;

    toggle_sync_pulse u_rel_sync (
        .clk_i   (clk_in1),
        .rst_n_i (rst_n),
        .tgl_i   (rd_rel_tgl),
        .pulse_o (rel_pulse)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        lidx_d       = lidx_q;
        rel_err_d    = rel_err_q;
        wen_d        = '0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        line_end     = 1'b0;
        abort        = 1'b0;
        pix_ready    = 1'b0;

        // run_q keeps ready low while in reset and for the first clock after it
        case (state_q)
            ST_IDLE: pix_ready = run_q;
            ST_FILL: pix_ready = run_q && (cnt_q < CNT_FULL);
            default: pix_ready = 1'b0;
        endcase
        xfer = pix_valid && pix_ready;

        if (xfer && pix_sof) begin
            abort = (state_q != ST_IDLE);
            if (abort) begin
                ptr_d = '0;
            end
            wen_d[ptr_d] = 1'b1;
            waddr_d      = '0;
            wdata_d      = pix_data;
            col_d        = AW'(1);
            lidx_d       = '0;
            state_d      = ST_FILL;
        end else if (xfer && state_q == ST_FILL) begin
            wen_d[ptr_q] = 1'b1;
            waddr_d      = col_q;
            wdata_d      = pix_data;
            if (col_q == COL_LAST) begin
                line_end    = 1'b1;
                line_done_d = 1'b1;
                col_d       = '0;
                ptr_d       = ptr_q + 1'b1;
                lidx_d      = lidx_q + 1'b1;
                if (lidx_q == LINE_LAST) begin
                    frame_done_d = 1'b1;
                    lidx_d       = '0;
                    state_d      = ST_IDLE;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A completion and a release in the same cycle cancel out
        if (abort) begin
            cnt_d = '0;
        end else if (line_end && !rel_pulse) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rel_pulse && !line_end) begin
            if (cnt_q == '0) begin
                rel_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (state_q == ST_WAIT && cnt_q < CNT_FULL) begin
            state_d = ST_FILL;
        end else if (line_end && !frame_done_d && cnt_d == CNT_FULL) begin
            state_d = ST_WAIT;
        end
    end

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            col_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            lidx_q       <= '0;
            rel_err_q    <= 1'b0;
            wen_q        <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            col_q        <= col_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            lidx_q       <= lidx_d;
            rel_err_q    <= rel_err_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bram0_wenb  = wen_q[0];
    assign bram1_wenb  = wen_q[1];
    assign bram2_wenb  = wen_q[2];
    assign bram3_wenb  = wen_q[3];
    assign bram_waddr  = waddr_q;
    assign bram_wdata  = wdata_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign wr_line_idx = lidx_q;
    assign buf_cnt     = cnt_q;
    assign rel_err     = rel_err_q;
endmodule

// File: tb/tb_bicubic_line_wr_ctrl.sv
// Directed bench for bicubic_line_wr_ctrl: vector table of line/release steps plus hand sequences.
`timescale 1ns/1ps
module tb_bicubic_line_wr_ctrl;
    localparam int IMG_W = 960;
    localparam int IMG_H = 12;
    localparam int AW    = 11;
    localparam int OP_LINE = 0;
    localparam int OP_LREL = 1;
    localparam int OP_REL  = 2;

    logic          clk = 1'b0;
    logic          rst_n, pix_sof, pix_valid, pix_ready, rd_rel_tgl;
    logic [7:0]    pix_data, bram_wdata;
    logic          bram0_wenb, bram1_wenb, bram2_wenb, bram3_wenb;
    logic [AW-1:0] bram_waddr;
    logic          line_done, frame_done, rel_err;
    logic [10:0]   wr_line_idx;
    logic [2:0]    buf_cnt;

    int errors = 0;
    int checks = 0;

    // what the current pixel on the bus should produce if it transfers
    bit   exp_wr, exp_ld, exp_fd;
    int   exp_buf, exp_addr;
    // write expected on the cycle after a transfer
    bit   p_vld, p_ld, p_fd;
    int   p_buf, p_addr;
    logic [7:0] p_dat;
    int   ld_cnt = 0;
    int   fd_cnt = 0;

    always #5 clk = ~clk;

    bicubic_line_wr_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk_in1(clk), .rst_n(rst_n), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .rd_rel_tgl(rd_rel_tgl),
        .bram0_wenb(bram0_wenb), .bram1_wenb(bram1_wenb), .bram2_wenb(bram2_wenb),
        .bram3_wenb(bram3_wenb), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .line_done(line_done), .frame_done(frame_done), .wr_line_idx(wr_line_idx),
        .buf_cnt(buf_cnt), .rel_err(rel_err)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            p_vld = 1'b0;
        end else begin
            chk("wenb", int'({bram3_wenb, bram2_wenb, bram1_wenb, bram0_wenb}), p_vld ? (1 << p_buf) : 0);
            if (p_vld) begin
                chk("waddr", int'(bram_waddr), p_addr);
                chk("wdata", int'(bram_wdata), int'(p_dat));
            end
            chk("line_done", int'(line_done), int'(p_vld && p_ld));
            chk("frame_done", int'(frame_done), int'(p_vld && p_fd));
            ld_cnt += int'(line_done);
            fd_cnt += int'(frame_done);
            p_vld  = pix_valid && pix_ready && exp_wr;
            p_buf  = exp_buf;
            p_addr = exp_addr;
            p_dat  = pix_data;
            p_ld   = exp_ld;
            p_fd   = exp_fd;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // called at posedge+1; returns at posedge+1 just after the transfer edge
    task automatic wait_xfer();
        int n = 0;
        bit rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) begin
            chk("xfer_timeout", 0, 1);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    task automatic send_cols(input int first, input int last, input bit sof, input int bufi,
                             input bit last_line, input int rel_col);
        for (int c = first; c <= last; c++) begin
            pix_valid = 1'b1;
            pix_sof   = sof && (c == first);
            pix_data  = 8'(c);
            exp_wr    = 1'b1;
            exp_buf   = bufi;
            exp_addr  = c;
            exp_ld    = (c == IMG_W - 1);
            exp_fd    = (c == IMG_W - 1) && last_line;
            if (c == rel_col) rd_rel_tgl = ~rd_rel_tgl;
            wait_xfer();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        exp_wr    = 1'b0;
    endtask

    task automatic release_wait();
        rd_rel_tgl = ~rd_rel_tgl;
        repeat (6) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int op;
        bit sof;
        int bufi;
        int cnt;
        int rdy;
        int lidx;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   n, ld_base, fd_base;
        bit   rdy;

        vt[0] = '{OP_LINE, 1'b1, 0, 1, 1, 1};
        vt[1] = '{OP_LINE, 1'b0, 1, 2, 1, 2};
        vt[2] = '{OP_LREL, 1'b0, 2, 2, 1, 3};
        vt[3] = '{OP_REL,  1'b0, 0, 1, 1, 3};
        vt[4] = '{OP_LINE, 1'b0, 3, 2, 1, 4};
        vt[5] = '{OP_LINE, 1'b0, 0, 3, 1, 5};
        vt[6] = '{OP_LINE, 1'b0, 1, 4, 0, 6};

        rst_n = 1'b0; pix_sof = 1'b0; pix_valid = 1'b0; pix_data = '0; rd_rel_tgl = 1'b0;
        exp_wr = 1'b0; exp_ld = 1'b0; exp_fd = 1'b0; exp_buf = 0; exp_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wenb", int'({bram3_wenb, bram2_wenb, bram1_wenb, bram0_wenb}), 0);
        chk("rst_waddr", bram_waddr, 0);
        chk("rst_wdata", bram_wdata, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_lidx", wr_line_idx, 0);
        chk("rst_cnt", buf_cnt, 0);
        chk("rst_rel_err", rel_err, 0);
        chk("rst_ready", pix_ready, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", pix_ready, 1);

        // release with nothing buffered
        release_wait();
        chk("empty_rel_err", rel_err, 1);
        chk("empty_rel_cnt", buf_cnt, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("rel_err_sticky", rel_err, 1);
        rst_n = 1'b0;
        rd_rel_tgl = 1'b0;
        #1;
        chk("rel_err_async_clear", rel_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            case (vt[i].op)
                OP_LINE: send_cols(0, IMG_W - 1, vt[i].sof, vt[i].bufi, 1'b0, -1);
                OP_LREL: send_cols(0, IMG_W - 1, vt[i].sof, vt[i].bufi, 1'b0, IMG_W - 3);
                default: release_wait();
            endcase
            chk($sformatf("vec%0d_cnt", i), buf_cnt, vt[i].cnt);
            chk($sformatf("vec%0d_ready", i), pix_ready, vt[i].rdy);
            chk($sformatf("vec%0d_lidx", i), wr_line_idx, vt[i].lidx);
        end

        // bank full: next line's first pixel must stall until a release
        pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'd0;
        exp_wr = 1'b1; exp_buf = 2; exp_addr = 0; exp_ld = 1'b0; exp_fd = 1'b0;
        rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            rdy |= pix_ready;
            @(posedge clk);
            #1;
        end
        chk("stall_ready", rdy, 0);
        chk("stall_cnt", buf_cnt, 4);
        rd_rel_tgl = ~rd_rel_tgl;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            rdy = pix_ready;
        end
        chk("rel_ready", rdy, 1);
        chk("rel_within_4", int'(n <= 4), 1);
        chk("rel_cnt", buf_cnt, 3);
        @(posedge clk);
        #1;
        send_cols(1, IMG_W - 1, 1'b0, 2, 1'b0, -1);
        chk("refill_cnt", buf_cnt, 4);
        chk("refill_lidx", wr_line_idx, 7);

        // sof in the middle of a line aborts the frame
        release_wait();
        release_wait();
        chk("abort_pre_cnt", buf_cnt, 2);
        send_cols(0, 499, 1'b0, 3, 1'b0, -1);
        ld_base = ld_cnt;
        fd_base = fd_cnt;
        send_cols(0, 0, 1'b1, 0, 1'b0, -1);
        chk("abort_no_line_done", line_done, 0);
        chk("abort_cnt", buf_cnt, 0);
        chk("abort_lidx", wr_line_idx, 0);
        send_cols(1, IMG_W - 1, 1'b0, 0, 1'b0, -1);
        chk("abort_line0_cnt", buf_cnt, 1);

        // rest of the frame, releasing after each line from the 4th on
        for (int l = 1; l < IMG_H; l++) begin
            send_cols(0, IMG_W - 1, 1'b0, l % 4, l == IMG_H - 1, -1);
            if (l >= 3 && l <= IMG_H - 2) rd_rel_tgl = ~rd_rel_tgl;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("frame_line_dones", ld_cnt - ld_base, IMG_H);
        chk("frame_dones", fd_cnt - fd_base, 1);
        chk("frame_lidx", wr_line_idx, 0);
        chk("frame_cnt", buf_cnt, 4);
        chk("frame_idle_ready", pix_ready, 1);

        // pixels without sof in IDLE are dropped
        pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'h77; exp_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;

        // async reset while a write enable is high
        pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'h3C;
        exp_wr = 1'b1; exp_buf = 0; exp_addr = 0; exp_ld = 1'b0; exp_fd = 1'b0;
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_sof = 1'b0; exp_wr = 1'b0;
        chk("pre_reset_wen0", bram0_wenb, 1);
        chk("pre_reset_wdata", bram_wdata, 8'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wenb", int'({bram3_wenb, bram2_wenb, bram1_wenb, bram0_wenb}), 0);
        chk("async_rst_cnt", buf_cnt, 0);
        chk("async_rst_ready", pix_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bicubic_line_wr_ctrl.md
Name: bicubic_line_wr_ctrl

Overview:
- Write-side controller for the 4-line x 4-copy bicubic line-buffer bank.
- Accepts the incoming 8-bit pixel stream in the write clock domain and writes each image row to one of 4 line buffers, round-robin.
- Drives the shared write address and data plus one write enable per line buffer.
- Tracks how many buffered lines are unconsumed and back-pressures the source when all 4 are full; line releases arrive from the read-clock interpolator as a toggle.

Parameters:
- IMG_W, 960: pixels per input line; must be <= 2048 (11-bit address).
- IMG_H, 540: lines per input frame.
- AW, 11: line-buffer address width.

Ports:
- clk_in1  in  1  write-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_sof  in  1  start-of-frame pulse, coincident with the first pixel's pix_valid.
- pix_valid  in  1  input pixel valid.
- pix_data  in  8  input pixel.
- pix_ready  out  1  source may present a pixel; transfer = pix_valid & pix_ready.
- rd_rel_tgl  in  1  read-domain toggle; each edge releases the oldest buffered line.
- bram0_wenb  out  1  write enable, line buffer 0.
- bram1_wenb  out  1  write enable, line buffer 1.
- bram2_wenb  out  1  write enable, line buffer 2.
- bram3_wenb  out  1  write enable, line buffer 3.
- bram_waddr  out  AW  write address, shared by all buffers.
- bram_wdata  out  8  write data, shared by all buffers.
- line_done  out  1  1-cycle pulse when the last pixel of a line is written.
- frame_done  out  1  1-cycle pulse when the last line of a frame is written.
- wr_line_idx  out  11  index of the line currently being written (0..IMG_H-1).
- buf_cnt  out  3  number of unconsumed lines held (0..4).
- rel_err  out  1  sticky flag: a release arrived while buf_cnt==0.

Behaviour:
- Reset values: all wenb 0; waddr 0; wdata 0; line_done 0; frame_done 0; wr_line_idx 0; buf_cnt 0; rel_err 0; line pointer 0; state IDLE; pix_ready 0.
- States:
  - IDLE: pix_ready=1. Pixels arriving without pix_sof are dropped. A transfer with pix_sof writes pixel 0 and moves to FILL.
  - FILL: each transfer writes one pixel at the column counter, then increments the column counter.
    - Column IMG_W-1 -> line_done pulses, column clears, line pointer advances (3 wraps to 0), buf_cnt increments.
    - If that line is also IMG_H-1 -> frame_done pulses with line_done; go to IDLE.
  - WAIT: entered from FILL when a line completes with buf_cnt reaching 4. pix_ready=0. Returns to FILL when buf_cnt<4.
- pix_ready: 1 in IDLE; in FILL while buf_cnt<4; 0 in WAIT.
- Write path is registered, 1-cycle latency: a transfer in cycle N drives wenb[ptr]=1, waddr=column, wdata=pixel in cycle N+1. Exactly one wenb is high, for one cycle.
- Release synchroniser: rd_rel_tgl passes a 2-flop synchroniser, then a 3rd flop; an XOR gives a 1-cycle release pulse.
- buf_cnt update:
  - Line completion only: +1.
  - Release only: -1.
  - Both in the same cycle: unchanged.
  - Release with buf_cnt==0: no change, rel_err set (cleared only by reset).
- pix_sof while in FILL or WAIT: abort the current frame.
  - buf_cnt=0, line pointer=0, wr_line_idx=0.
  - The sof pixel is written to buffer 0, address 0; state becomes FILL.
  - No line_done is issued for the aborted line.
- wr_line_idx: increments at each line_done; clears at frame_done and on sof.
- Async reset mid-line: all state clears immediately; wenb drops without waiting for a clock.

Decomposition:
- Shared package bicubic_pkg holds IMG_W, IMG_H, AW, pixel width 8, NUM_LINES=4, and the state encoding (IDLE, FILL, WAIT).
- One sub-module is natural: toggle_sync_pulse (2-flop synchroniser plus edge detect), reusable for other read-to-write domain handshakes.

Test Plan:
- Reset, then sof and 960 valid pixels with values col[7:0] -> bram0_wenb high 960 cycles, each one cycle after its transfer; waddr 0..959; line_done at waddr 959; buf_cnt=1.
- Write 4 full lines with no release -> wenb order bram0..bram3; buf_cnt=4; pix_ready=0; 5th-line pixels stall. One rd_rel_tgl edge -> within 4 cycles buf_cnt=3, pix_ready=1, next line writes bram0.
- Release pulse in the same cycle as line_done with buf_cnt=2 -> buf_cnt stays 2.
- Toggle rd_rel_tgl with buf_cnt=0 -> rel_err=1 and stays 1; buf_cnt stays 0.
- sof at column 500 of line 2 -> no line_done; the next write is bram0_wenb at waddr 0; buf_cnt=0; wr_line_idx=0.
- Full 960x540 frame with a release after every line beyond the 4th -> exactly 540 line_done pulses, one frame_done coincident with the last, state IDLE, wr_line_idx=0.
